neo_rx_merge_arbiter: RTL and testbench

//  Sits between N per-chip Neo RX handshake receivers and the FPGA spike core; merges their spike packets onto one output stream.

---
 rtl/neo_rx_merge_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_neo_rx_merge_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_rx_merge_arbiter.sv
// Merges N per-chip Neo RX packet streams into one round-robin arbitrated output, and sequences
// the per-receiver chip-boundary offset writes after a single cfg_start pulse.
module neo_rx_merge_arbiter #(
  parameter int unsigned GLOBAL_NEURON = 1024,
  parameter int unsigned N_CH          = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PKT_W         = 5 + 1 + $clog2(GLOBAL_NEURON),
  parameter int unsigned OFS_W         = $clog2(GLOBAL_NEURON)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ext_spike_in,
  input  logic [N_CH*PKT_W-1:0]    ext_packet_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_W-1:0]         out_packet,
  output logic [$clog2(N_CH)-1:0]  out_chan,
  output logic [N_CH-1:0]          ovf_flag,
  input  logic                     ovf_clr,
  input  logic                     cfg_start,
  input  logic [OFS_W-1:0]         cfg_base,
  input  logic [OFS_W-1:0]         cfg_stride,
  output logic [N_CH-1:0]          boundary_w_en,
  output logic [OFS_W-1:0]         chip_boundary_offset,
  output logic                     cfg_busy,
  output logic                     cfg_done
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    CfgIdle,
    CfgWrite,
    CfgDone
  } cfg_state_e;

  // Per-channel FIFO storage and pointers
  logic [PKT_W-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N_CH];
  logic [PTR_W-1:0] rd_ptr_q [N_CH];
  logic [CNT_W-1:0] cnt_q    [N_CH];

  logic [N_CH-1:0] fifo_empty;
  logic [N_CH-1:0] fifo_full;
  logic [N_CH-1:0] push_ok;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] ovf_set;

  logic [CH_W-1:0] rr_q;
  logic [CH_W-1:0] grant_ch;
  logic            grant_valid;
  logic            load_en;

  cfg_state_e       cfg_state_q;
  logic [CH_W-1:0]  cfg_idx_q;
  logic [OFS_W-1:0] cfg_stride_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fifo_empty[i] = (cnt_q[i] == '0);
      fifo_full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  // Walk downward so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    int c;
    grant_valid = 1'b0;
    grant_ch    = '0;
    c           = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = (int'(rr_q) + k) % int'(N_CH);
      if (!fifo_empty[c]) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'(c);
      end
    end
  end

  assign load_en = !out_valid || out_ready;

  always_comb begin
    pop = '0;
    if (load_en && grant_valid) begin
      pop = N_CH'(1) << grant_ch;
    end
  end

  // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
  assign push_ok = ext_spike_in & (~fifo_full | pop);
  assign ovf_set = ext_spike_in & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wr_ptr_q[i]] <= ext_packet_in[i*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push_ok[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        end
        cnt_q[i] <= cnt_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= '0;
    end else begin
      ovf_flag <= (ovf_flag & ~{N_CH{ovf_clr}}) | ovf_set;
    end
  end

  // Output register: holds stable while stalled, reloads from the granted FIFO otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_chan   <= '0;
      rr_q       <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid  <= 1'b1;
        out_packet <= mem_q[grant_ch][rd_ptr_q[grant_ch]];
        out_chan   <= grant_ch;
        rr_q       <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Offset is accumulated rather than multiplied; the modular wrap is identical.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_state_q          <= CfgIdle;
      cfg_idx_q            <= '0;
      cfg_stride_q         <= '0;
      boundary_w_en        <= '0;
      chip_boundary_offset <= '0;
      cfg_busy             <= 1'b0;
      cfg_done             <= 1'b0;
    end else begin
      case (cfg_state_q)
        CfgIdle: begin
          if (cfg_start) begin
            cfg_state_q          <= CfgWrite;
            cfg_idx_q            <= '0;
            cfg_stride_q         <= cfg_stride;
            boundary_w_en        <= N_CH'(1);
            chip_boundary_offset <= cfg_base;
            cfg_busy             <= 1'b1;
          end
        end
        CfgWrite: begin
          if (cfg_idx_q == CH_W'(N_CH - 1)) begin
            cfg_state_q          <= CfgDone;
            boundary_w_en        <= '0;
            chip_boundary_offset <= '0;
            cfg_done             <= 1'b1;
          end else begin
            cfg_idx_q            <= cfg_idx_q + CH_W'(1);
            boundary_w_en        <= boundary_w_en << 1;
            chip_boundary_offset <= chip_boundary_offset + cfg_stride_q;
          end
        end
        CfgDone: begin
          cfg_state_q <= CfgIdle;
          cfg_done    <= 1'b0;
          cfg_busy    <= 1'b0;
        end
        default: begin
          cfg_state_q          <= CfgIdle;
          boundary_w_en        <= '0;
          chip_boundary_offset <= '0;
          cfg_busy             <= 1'b0;
          cfg_done             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neo_rx_merge_arbiter.sv
// Directed bench for neo_rx_merge_arbiter: latency, round-robin order, overflow,
// full-FIFO push+pop, offset configuration sequence and reset abort.
module tb_neo_rx_merge_arbiter;

  localparam int N_CH  = 4;
  localparam int PKT_W = 16;
  localparam int OFS_W = 10;
  localparam int CH_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ext_spike_in;
  logic [N_CH*PKT_W-1:0] ext_packet_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [PKT_W-1:0]      out_packet;
  logic [CH_W-1:0]       out_chan;
  logic [N_CH-1:0]       ovf_flag;
  logic                  ovf_clr;
  logic                  cfg_start;
  logic [OFS_W-1:0]      cfg_base;
  logic [OFS_W-1:0]      cfg_stride;
  logic [N_CH-1:0]       boundary_w_en;
  logic [OFS_W-1:0]      chip_boundary_offset;
  logic                  cfg_busy;
  logic                  cfg_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neo_rx_merge_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .ext_spike_in         (ext_spike_in),
    .ext_packet_in        (ext_packet_in),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_packet           (out_packet),
    .out_chan             (out_chan),
    .ovf_flag             (ovf_flag),
    .ovf_clr              (ovf_clr),
    .cfg_start            (cfg_start),
    .cfg_base             (cfg_base),
    .cfg_stride           (cfg_stride),
    .boundary_w_en        (boundary_w_en),
    .chip_boundary_offset (chip_boundary_offset),
    .cfg_busy             (cfg_busy),
    .cfg_done             (cfg_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input int ch, input logic [PKT_W-1:0] p);
    ext_spike_in[ch]                  = 1'b1;
    ext_packet_in[ch*PKT_W +: PKT_W]  = p;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ext_spike_in  = '0;
    ext_packet_in = '0;
    out_ready     = 1'b0;
    ovf_clr       = 1'b0;
    cfg_start     = 1'b0;
    cfg_base      = '0;
    cfg_stride    = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_off [4] = '{10, 266, 522, 778};

  initial begin
    rst           = 1'b1;
    ext_spike_in  = '0;
    ext_packet_in = '0;
    out_ready     = 1'b0;
    ovf_clr       = 1'b0;
    cfg_start     = 1'b0;
    cfg_base      = '0;
    cfg_stride    = '0;

    // Reset state and single-packet latency
    do_reset();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ovf", ovf_flag, 0);
    check_eq("rst_wen", boundary_w_en, 0);
    check_eq("rst_ofs", chip_boundary_offset, 0);
    check_eq("rst_busy", cfg_busy, 0);
    check_eq("rst_done", cfg_done, 0);
    out_ready = 1'b1;
    spike(2, 16'h00A5);
    step();
    ext_spike_in = '0;
    check_eq("t1_lat1_valid", out_valid, 0);
    step();
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_pkt", out_packet, 32'h0A5);
    check_eq("t1_chan", out_chan, 2);
    step();
    check_eq("t1_drain", out_valid, 0);

    // Round-robin bursts across all channels
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int ch = 0; ch < N_CH; ch++) spike(ch, PKT_W'(b * 4 + ch + 1));
      step();
      ext_spike_in = '0;
      check_eq("t2_idle", out_valid, 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        step();
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_chan", out_chan, ch);
        check_eq("t2_pkt", out_packet, b * 4 + ch + 1);
      end
    end
    step();
    check_eq("t2_drain", out_valid, 0);

    // Overflow on ch1 with the output register already occupied
    do_reset();
    spike(0, 16'h0030);
    step();
    ext_spike_in = '0;
    step();
    check_eq("t3_hold_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check_eq("t3_no_ovf_yet", ovf_flag, 0);
      spike(1, PKT_W'(16'h11 + k));
      step();
      ext_spike_in = '0;
    end
    check_eq("t3_ovf", ovf_flag, 4'b0010);
    check_eq("t3_held_pkt", out_packet, 32'h30);
    check_eq("t3_held_chan", out_chan, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t3_pkt", out_packet, 32'h11 + k);
      check_eq("t3_chan", out_chan, 1);
    end
    step();
    check_eq("t3_drain", out_valid, 0);
    check_eq("t3_ovf_sticky", ovf_flag, 4'b0010);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("t3_ovf_clr", ovf_flag, 0);

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    spike(0, 16'h0040);
    step();
    ext_spike_in = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      spike(0, PKT_W'(16'h41 + k));
      step();
      ext_spike_in = '0;
    end
    check_eq("t4_full_no_ovf", ovf_flag, 0);
    spike(0, 16'h0045);
    out_ready = 1'b1;
    step();
    ext_spike_in = '0;
    check_eq("t4_ovf", ovf_flag, 0);
    check_eq("t4_pkt0", out_packet, 32'h41);
    for (int k = 1; k < 5; k++) begin
      step();
      check_eq("t4_valid", out_valid, 1);
      check_eq("t4_pkt", out_packet, 32'h41 + k);
    end
    step();
    check_eq("t4_drain", out_valid, 0);

    // Offset configuration sequence, with a cfg_start while busy
    do_reset();
    cfg_base   = 10'd10;
    cfg_stride = 10'd256;
    cfg_start  = 1'b1;
    step();
    cfg_start  = 1'b0;
    cfg_base   = 10'h3FF;
    cfg_stride = 10'd1;
    for (int idx = 0; idx < 4; idx++) begin
      check_eq("t5_wen", boundary_w_en, 32'd1 << idx);
      check_eq("t5_ofs", chip_boundary_offset, exp_off[idx]);
      check_eq("t5_busy", cfg_busy, 1);
      check_eq("t5_done_low", cfg_done, 0);
      cfg_start = (idx == 1);
      step();
    end
    cfg_start = 1'b0;
    check_eq("t5_done", cfg_done, 1);
    check_eq("t5_done_busy", cfg_busy, 1);
    check_eq("t5_done_wen", boundary_w_en, 0);
    check_eq("t5_done_ofs", chip_boundary_offset, 0);
    step();
    check_eq("t5_idle_done", cfg_done, 0);
    check_eq("t5_idle_busy", cfg_busy, 0);
    step();
    check_eq("t5_no_restart", cfg_busy, 0);

    // Reset mid-sequence drops packets and aborts configuration
    do_reset();
    spike(3, 16'h0077);
    step();
    ext_spike_in = '0;
    spike(3, 16'h0078);
    step();
    ext_spike_in = '0;
    cfg_base   = 10'd5;
    cfg_stride = 10'd1;
    cfg_start  = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    check_eq("t6_idx1_wen", boundary_w_en, 4'b0010);
    check_eq("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    check_eq("t6_wen", boundary_w_en, 0);
    check_eq("t6_busy", cfg_busy, 0);
    check_eq("t6_done", cfg_done, 0);
    check_eq("t6_valid", out_valid, 0);
    check_eq("t6_ofs", chip_boundary_offset, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("t6_post_valid", out_valid, 0);
      check_eq("t6_post_done", cfg_done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
